transpuesta_ctrl: RTL and testbench

Sequencer for the 32x32 transpose buffer between the first (row) and second (column) 1-D DCT stages.
- Accepts rows from stage 1 using a valid/ready handshake and drives the buffer `load` strobe.
- After a full block is in, drives `unload` to stream columns to stage 2 with valid/ready backpressure.
- Supports HEVC transform sizes 4/8/16/32, selected per block.

---
 rtl/transpuesta_ctrl.sv | 112 +++++++++++
 tb/tb_transpuesta_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/transpuesta_ctrl.sv
// Load/unload sequencer for the 32x32 transpose buffer between the row and column DCT stages.
// Latency: out_valid rises the cycle after the final row load; blk_done follows the last unload by one cycle.
// Backpressure: in_ready is low while draining; out_ready=0 freezes column count, state and buffer contents.
module transpuesta_ctrl #(
    parameter int N_MAX = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       size,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_col,
    output logic             out_last,
    output logic             load,
    output logic             unload,
    output logic             blk_done,
    output logic             busy
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] col_cnt;
    logic [1:0]       len_code;

    logic [1:0]       eff_code;
    logic [CNT_W-1:0] row_last_idx;
    logic [CNT_W-1:0] col_last_idx;
    logic             row_last;
    logic             col_last;

    // Index of the last row/column for a size code: (4 << code) - 1, never beyond the buffer.
    function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] code);
        int len;
        len = 4 << code;
        if (len > N_MAX) begin
            len = N_MAX;
        end
        return CNT_W'(len - 1);
    endfunction

    // The first row of a block takes its length from the live size input; later rows use the latched code.
    always_comb begin
        eff_code     = (row_cnt == '0) ? size : len_code;
        row_last_idx = last_idx(eff_code);
        col_last_idx = last_idx(len_code);
        row_last     = (row_cnt == row_last_idx);
        col_last     = (col_cnt == col_last_idx);
    end

    // Handshake and status decode; buffer strobes are suppressed while reset is held so the
    // buffer sees a clean clear on the shared reset net.
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
        load      = in_valid & in_ready & ~rst;
        unload    = out_valid & out_ready & ~rst;
        out_col   = col_cnt;
        out_last  = out_valid & col_last;
        busy      = (state == DRAIN) | (row_cnt != '0);
    end

    // Sequencer: count rows in FILL, columns in DRAIN, flip state on the last beat of each.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            row_cnt  <= '0;
            col_cnt  <= '0;
            len_code <= 2'd3;
            blk_done <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            case (state)
                FILL: begin
                    if (load) begin
                        if (row_cnt == '0) begin
                            len_code <= size;
                        end
                        if (row_last) begin
                            row_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (unload) begin
                        if (col_last) begin
                            col_cnt  <= '0;
                            state    <= FILL;
                            blk_done <= 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transpuesta_ctrl.sv
// Bench for transpuesta_ctrl: directed block scenarios plus random traffic against a count-based model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The model tracks phase, rows/columns done and block length as plain integers.
module tb_transpuesta_ctrl;

    localparam int N_MAX = 32;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       size = 2'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_col;
    logic             out_last;
    logic             load;
    logic             unload;
    logic             blk_done;
    logic             busy;

    transpuesta_ctrl #(.N_MAX(N_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .size      (size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_col   (out_col),
        .out_last  (out_last),
        .load      (load),
        .unload    (unload),
        .blk_done  (blk_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = taking rows, 1 = giving columns.
    int m_phase = 0;
    int m_rows  = 0;
    int m_cols  = 0;
    int m_code  = 3;
    int m_done  = 0;

    // Observed event counters.
    int n_load = 0;
    int n_unl  = 0;
    int n_done = 0;
    int col_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int blk_len(input int code);
        return 4 << code;
    endfunction

    task automatic tick(input bit iv, input bit orr, input logic [1:0] sz, input bit r, input bit en);
        int exp_load;
        int exp_unl;
        @(negedge clk);
        in_valid  = iv;
        out_ready = orr;
        size      = sz;
        rst       = r;
        #1;
        exp_load = (!r && m_phase == 0 && iv) ? 1 : 0;
        exp_unl  = (!r && m_phase == 1 && orr) ? 1 : 0;
        if (en) begin
            chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 1));
            chk("load",      32'(load),      32'(exp_load));
            chk("unload",    32'(unload),    32'(exp_unl));
            chk("out_col",   32'(out_col),   32'(m_cols));
            chk("out_last",  32'(out_last),  32'(m_phase == 1 && m_cols == blk_len(m_code) - 1));
            chk("busy",      32'(busy),      32'(m_phase == 1 || m_rows != 0));
            chk("blk_done",  32'(blk_done),  32'(m_done));
            chk("exclusive", 32'(load & unload), 32'd0);
        end
        if (load === 1'b1) n_load++;
        if (unload === 1'b1) begin
            n_unl++;
            col_q.push_back(int'(out_col));
        end
        if (blk_done === 1'b1) n_done++;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_rows = 0; m_cols = 0; m_code = 3; m_done = 0;
        end else begin
            m_done = 0;
            if (m_phase == 0) begin
                if (iv) begin
                    if (m_rows == 0) m_code = int'(sz);
                    m_rows++;
                    if (m_rows == blk_len(m_code)) begin
                        m_rows  = 0;
                        m_phase = 1;
                    end
                end
            end else if (orr) begin
                m_cols++;
                if (m_cols == blk_len(m_code)) begin
                    m_cols  = 0;
                    m_phase = 0;
                    m_done  = 1;
                end
            end
        end
    endtask

    initial begin
        int l0, u0, d0, k;
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // Reset: first edge from unknown state unchecked, second checked.
        tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("reset_len_code_out_last", 32'(out_last), 32'd0);

        // 1: full 32x32 block, continuous valid/ready.
        l0 = n_load; u0 = n_unl; d0 = n_done; col_q.delete();
        for (int i = 0; i < 64; i++) tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        chk("t1_loads",   32'(n_load - l0), 32'd32);
        chk("t1_unloads", 32'(n_unl - u0),  32'd32);
        chk("t1_done",    32'(n_done - d0), 32'd1);
        for (int i = 0; i < col_q.size(); i++) chk("t1_col_seq", 32'(col_q[i]), 32'(i));

        // 2: size=0 block, size changed after the first row must not matter.
        l0 = n_load; u0 = n_unl; col_q.delete();
        tick(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("t2_loads",   32'(n_load - l0), 32'd4);
        chk("t2_unloads", 32'(n_unl - u0),  32'd4);
        chk("t2_ncols",   32'(col_q.size()), 32'd4);
        for (int i = 0; i < col_q.size(); i++) chk("t2_col_seq", 32'(col_q[i]), 32'(i));

        // 3: size=1 block drained with gappy out_ready while in_valid stays high.
        l0 = n_load; u0 = n_unl;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
        k = 0;
        while (m_phase == 1 && k < 40) begin
            tick(1'b1, pat[k % 4], 2'd1, 1'b0, 1'b1);
            k++;
        end
        chk("t3_drain_bound", 32'(k < 40), 32'd1);
        chk("t3_loads",   32'(n_load - l0), 32'd8);
        chk("t3_unloads", 32'(n_unl - u0),  32'd8);
        tick(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);

        // 4: two back-to-back size=1 blocks.
        l0 = n_load; u0 = n_unl; d0 = n_done;
        for (int i = 0; i < 32; i++) tick(1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        chk("t4_loads",   32'(n_load - l0), 32'd16);
        chk("t4_unloads", 32'(n_unl - u0),  32'd16);
        chk("t4_done",    32'(n_done - d0), 32'd2);

        // 5: abort after 10 of 32 rows, then a full size=2 block.
        l0 = n_load; u0 = n_unl; d0 = n_done;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        for (int i = 0; i < 32; i++) tick(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("t5_loads",   32'(n_load - l0), 32'd26);
        chk("t5_unloads", 32'(n_unl - u0),  32'd16);
        chk("t5_done",    32'(n_done - d0), 32'd1);

        // 6: gapped in_valid, size=3: 32 loads over 63 cycles.
        l0 = n_load;
        for (int i = 0; i < 63; i++) begin
            tick(((i % 2) == 0), 1'b1, 2'd3, 1'b0, 1'b1);
            if (i == 61) chk("t6_still_fill", 32'(in_ready), 32'd1);
        end
        chk("t6_loads", 32'(n_load - l0), 32'd32);
        tick(1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("t6_in_drain", 32'(out_valid), 32'd1);
        for (int i = 0; i < 33; i++) tick(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) == 0), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
